spi_burst_ram: RTL and testbench

Parametrised single-port RAM that sits behind the SPI slave and executes the 2-bit-opcode command stream (write-address, write-data, read-address, read-data). It generalises data width and depth independently and adds burst auto-increment address pointers with wrap-around. It also adds a valid/ready backpressure handshake on the read-data return path, with overflow reporting.

---
 rtl/spi_burst_ram.sv | 139 +++++++++++++
 tb/tb_spi_burst_ram.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_ram.sv
// ---------------------------------------------------------------------------
// spi_burst_ram
//
// Single-port word RAM driven by the 2-bit-opcode command stream coming out
// of the SPI slave. Commands carry an opcode in the top two bits and a
// DATA_WIDTH payload below it:
//   00 WR_ADDR  load the write pointer
//   01 WR_DATA  write payload to mem[wr_ptr]
//   10 RD_ADDR  load the read pointer
//   11 RD_DATA  fetch mem[rd_ptr] into the tx register
//
// Optional feature (macro SPI_RAM_AUTOINC_EN): when defined, wr_ptr
// advances after every WR_DATA and rd_ptr after every accepted RD_DATA.
// Both pointers wrap from MEM_DEPTH-1 to 0. When the macro is undefined,
// the pointers move only on WR_ADDR/RD_ADDR.
//
// Parameters:
//   MEM_DEPTH   number of words, >= 2, any value
//   DATA_WIDTH  word width
//   ADDR_WIDTH  pointer width, must be <= DATA_WIDTH
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset (memory contents kept)
//   rx_valid  command strobe, one command per asserted cycle
//   rx_data   {opcode[1:0], payload[DATA_WIDTH-1:0]}
//   tx_ready  consumer takes tx_data this cycle
//   tx_valid  tx_data holds an unconsumed read word
//   tx_data   read word (changes only on an accepted RD_DATA or reset)
//   ovf_err   one-cycle pulse: an RD_DATA was dropped
// ---------------------------------------------------------------------------
module spi_burst_ram #(
    parameter int MEM_DEPTH  = 256,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH+1:0] rx_data,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  ovf_err
);

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic [1:0]            opcode;
    logic [DATA_WIDTH-1:0] payload;
    logic                  rd_cmd;
    logic                  rd_accept;
    logic                  rd_reject;

    assign opcode  = rx_data[DATA_WIDTH+1:DATA_WIDTH];
    assign payload = rx_data[DATA_WIDTH-1:0];

    // A loaded address is below 2**ADDR_WIDTH < 2*MEM_DEPTH, so a single
    // conditional subtraction is a full modulo-MEM_DEPTH reduction.
    function automatic logic [ADDR_WIDTH-1:0] load_ptr(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] ext;
        ext = {1'b0, a};
        if (ext >= DEPTH_EXT) begin
            ext = ext - DEPTH_EXT;
        end
        return ext[ADDR_WIDTH-1:0];
    endfunction

`ifdef SPI_RAM_AUTOINC_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    function automatic logic [ADDR_WIDTH-1:0] inc_ptr(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction
`endif

    // Read-return handshake (valid/ready):
    //   - a word is transferred on any cycle where tx_valid and tx_ready are
    //     both high;
    //   - tx_valid, once raised, stays high and tx_data stays stable until
    //     that transfer happens;
    //   - an RD_DATA is accepted when the tx register is empty or is being
    //     drained in the same cycle; otherwise it is dropped and ovf_err
    //     pulses on the following cycle.
    assign rd_cmd    = rx_valid && (opcode == OP_RD_DATA);
    assign rd_accept = rd_cmd && (!tx_valid || tx_ready);
    assign rd_reject = rd_cmd && tx_valid && !tx_ready;

    // Storage has no reset; writes are suppressed while reset is held so
    // a command stream during reset cannot disturb retained contents.
    always_ff @(posedge clk) begin
        if (rst_n && rx_valid && (opcode == OP_WR_DATA)) begin
            mem[wr_ptr] <= payload;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            ovf_err  <= 1'b0;
        end else begin
            ovf_err <= rd_reject;

            if (rx_valid) begin
                case (opcode)
                    OP_WR_ADDR: wr_ptr <= load_ptr(payload[ADDR_WIDTH-1:0]);
`ifdef SPI_RAM_AUTOINC_EN
                    OP_WR_DATA: wr_ptr <= inc_ptr(wr_ptr);
`endif
                    OP_RD_ADDR: rd_ptr <= load_ptr(payload[ADDR_WIDTH-1:0]);
                    default: ;
                endcase
            end

            if (rd_accept) begin
                tx_data  <= mem[rd_ptr];
                tx_valid <= 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                rd_ptr   <= inc_ptr(rd_ptr);
`endif
            end else if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_burst_ram.sv
// ---------------------------------------------------------------------------
// tb_spi_burst_ram
//
// Directed bench for spi_burst_ram at default parameters (256 x 8). Each
// command step updates a small reference model of the pointers, memory and
// tx register; accepted reads push their expected word to exp_q, which is
// popped and compared one cycle later when the DUT presents the word.
// Directed constant checks from the test plan are layered on top.
// ---------------------------------------------------------------------------
module tb_spi_burst_ram;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [9:0] rx_data;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       ovf_err;

    spi_burst_ram #(
        .MEM_DEPTH (256),
        .DATA_WIDTH(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .tx_ready(tx_ready),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .ovf_err (ovf_err)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model + scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] mem_m [256];
    logic [7:0] m_wr;
    logic [7:0] m_rd;
    logic [7:0] m_txd;
    logic       m_txv;
    logic       m_ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 10'h3FF;
        tx_ready = 1'b1;
        m_wr  = 8'h00;
        m_rd  = 8'h00;
        m_txd = 8'h00;
        m_txv = 1'b0;
        m_ovf = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data",  {24'd0, tx_data},  32'd0);
        check("rst_ovf_err",  {31'd0, ovf_err},  32'd0);
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [7:0] pay,
                        input logic rdy);
        logic       acc;
        logic [7:0] got;
        rst_n    = 1'b1;
        rx_valid = v;
        rx_data  = {op, pay};
        tx_ready = rdy;

        acc   = v && (op == 2'b11) && (!m_txv || rdy);
        m_ovf = v && (op == 2'b11) && m_txv && !rdy;
        if (acc) begin
            exp_q.push_back(mem_m[m_rd]);
            m_txd = mem_m[m_rd];
            m_txv = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            m_rd  = m_rd + 8'd1;
`endif
        end else if (m_txv && rdy) begin
            m_txv = 1'b0;
        end
        if (v) begin
            case (op)
                2'b00: m_wr = pay;
                2'b01: begin
                    mem_m[m_wr] = pay;
`ifdef SPI_RAM_AUTOINC_EN
                    m_wr = m_wr + 8'd1;
`endif
                end
                2'b10: m_rd = pay;
                default: ;
            endcase
        end

        @(posedge clk);
        #1;
        check("tx_valid", {31'd0, tx_valid}, {31'd0, m_txv});
        check("tx_data",  {24'd0, tx_data},  {24'd0, m_txd});
        check("ovf_err",  {31'd0, ovf_err},  {31'd0, m_ovf});
        if (acc) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd0, 32'd1);
            end else begin
                got = exp_q.pop_front();
                check("sb_word", {24'd0, tx_data}, {24'd0, got});
            end
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 2'b00, 8'h00, rdy);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        tx_ready = 1'b1;

        // Reset held two cycles with a read command on the bus
        do_reset();
        do_reset();

        // Single write/read
        step(1'b1, 2'b00, 8'h10, 1'b1);
        step(1'b1, 2'b01, 8'hA5, 1'b1);
        step(1'b1, 2'b10, 8'h10, 1'b1);
        step(1'b1, 2'b11, 8'h00, 1'b1);
        check("single_valid", {31'd0, tx_valid}, 32'd1);
        check("single_data",  {24'd0, tx_data},  32'hA5);
        idle(1'b1);
        check("single_drain", {31'd0, tx_valid}, 32'd0);

        // Burst with wrap; mem[0x00] seeded so an untouched word is visible
        step(1'b1, 2'b00, 8'h00, 1'b1);
        step(1'b1, 2'b01, 8'hEE, 1'b1);
        step(1'b1, 2'b00, 8'hFF, 1'b1);
        step(1'b1, 2'b01, 8'h11, 1'b1);
        step(1'b1, 2'b01, 8'h22, 1'b1);
        step(1'b1, 2'b10, 8'hFF, 1'b1);
        step(1'b1, 2'b11, 8'h00, 1'b1);
`ifdef SPI_RAM_AUTOINC_EN
        check("burst_rd0", {24'd0, tx_data}, 32'h11);
`else
        check("burst_rd0", {24'd0, tx_data}, 32'h22);
`endif
        step(1'b1, 2'b11, 8'h00, 1'b1);
        check("burst_rd1", {24'd0, tx_data}, 32'h22);
        check("burst_valid", {31'd0, tx_valid}, 32'd1);
        step(1'b1, 2'b10, 8'h00, 1'b1);
        step(1'b1, 2'b11, 8'h00, 1'b1);
`ifdef SPI_RAM_AUTOINC_EN
        check("burst_wrap0", {24'd0, tx_data}, 32'h22);
`else
        check("burst_wrap0", {24'd0, tx_data}, 32'hEE);
`endif
        idle(1'b1);

        // Backpressure with a dropped read
        step(1'b1, 2'b00, 8'h40, 1'b1);
        step(1'b1, 2'b01, 8'h5A, 1'b1);
        step(1'b1, 2'b00, 8'h41, 1'b1);
        step(1'b1, 2'b01, 8'h6B, 1'b1);
        step(1'b1, 2'b10, 8'h40, 1'b1);
        step(1'b1, 2'b11, 8'h00, 1'b0);
        check("bp_first", {24'd0, tx_data}, 32'h5A);
        check("bp_no_ovf", {31'd0, ovf_err}, 32'd0);
        step(1'b1, 2'b11, 8'h00, 1'b0);
        check("bp_held",  {24'd0, tx_data}, 32'h5A);
        check("bp_ovf",   {31'd0, ovf_err}, 32'd1);
        idle(1'b0);
        check("bp_ovf_one", {31'd0, ovf_err}, 32'd0);
        check("bp_still_valid", {31'd0, tx_valid}, 32'd1);

        // Simultaneous consume and read
        step(1'b1, 2'b11, 8'h00, 1'b1);
`ifdef SPI_RAM_AUTOINC_EN
        check("sim_data", {24'd0, tx_data}, 32'h6B);
`else
        check("sim_data", {24'd0, tx_data}, 32'h5A);
`endif
        check("sim_valid", {31'd0, tx_valid}, 32'd1);
        check("sim_ovf",   {31'd0, ovf_err},  32'd0);
        idle(1'b1);

        // Reset mid-burst
        step(1'b1, 2'b00, 8'h80, 1'b1);
        step(1'b1, 2'b01, 8'h31, 1'b1);
        step(1'b1, 2'b10, 8'h80, 1'b1);
        step(1'b1, 2'b11, 8'h00, 1'b0);
        do_reset();
        step(1'b1, 2'b01, 8'h77, 1'b1);
        step(1'b1, 2'b10, 8'h00, 1'b1);
        step(1'b1, 2'b11, 8'h00, 1'b1);
        check("rst_burst_new", {24'd0, tx_data}, 32'h77);
        step(1'b1, 2'b10, 8'h80, 1'b1);
        step(1'b1, 2'b11, 8'h00, 1'b1);
        check("rst_burst_keep", {24'd0, tx_data}, 32'h31);
        step(1'b1, 2'b10, 8'h10, 1'b1);
        step(1'b1, 2'b11, 8'h00, 1'b1);
        check("rst_burst_old", {24'd0, tx_data}, 32'hA5);
        idle(1'b1);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
